// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: frame FSM, config staging, RX FIFO, error status and interrupt
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int PRSC_WIDTH = 6,
  parameter int TMO_CYC    = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_serial_data,
  input  logic                         i_rx_valid,
  input  logic                         i_rx_par_err,
  input  logic                         i_rx_stp_err,
  input  logic [WIDTH-1:0]             i_rx_data,
  input  logic                         i_cfg_we,
  input  logic [PRSC_WIDTH-1:0]        i_cfg_prescale,
  input  logic                         i_cfg_par_en,
  input  logic                         i_cfg_par_type,
  output logic [PRSC_WIDTH-1:0]        o_prescale,
  output logic                         o_parity_enable,
  output logic                         o_parity_type,
  input  logic                         i_rd_en,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH):0]       o_count,
  input  logic [$clog2(DEPTH):0]       i_thresh,
  input  logic                         i_clr_err,
  output logic                         o_par_flag,
  output logic                         o_stp_flag,
  output logic                         o_ovr_flag,
  output logic [7:0]                   o_err_cnt,
  output logic                         o_irq
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = PRSC_WIDTH + 4;
  localparam int TW  = $clog2(TMO_CYC + 1);
  localparam logic [PRSC_WIDTH-1:0] PRSC_RST = PRSC_WIDTH'(8);

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  state_t                 state_q, state_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [PRSC_WIDTH-1:0]  prsc_q, prsc_d, pend_prsc_q, pend_prsc_d;
  logic                   par_en_q, par_en_d, par_type_q, par_type_d;
  logic                   pend_vld_q, pend_vld_d, pend_par_en_q, pend_par_en_d;
  logic                   pend_par_type_q, pend_par_type_d;
  logic                   frame_err_q, frame_err_d;
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
  logic                   ovr_flag_q, ovr_flag_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   irq_q, irq_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic [WDW-1:0] wd_limit, wd_inc;
  logic leave_recv, err_now, err_evt, push_req, do_push, do_pop, ovr_evt;
  logic empty, full, timeout;

  always_comb begin
    state_d         = state_q;
    wd_d            = '0;
    leave_recv      = 1'b0;
    prsc_d          = prsc_q;
    par_en_d        = par_en_q;
    par_type_d      = par_type_q;
    pend_vld_d      = pend_vld_q;
    pend_prsc_d     = pend_prsc_q;
    pend_par_en_d   = pend_par_en_q;
    pend_par_type_d = pend_par_type_q;

    err_now  = i_rx_par_err | i_rx_stp_err;
    wd_limit = {4'b0000, prsc_q} * WDW'(12);
    wd_inc   = wd_q + WDW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!i_serial_data) state_d = ST_RECV;
        if (i_cfg_we) begin
          prsc_d     = i_cfg_prescale;
          par_en_d   = i_cfg_par_en;
          par_type_d = i_cfg_par_type;
        end
      end
      default: begin
        wd_d = wd_inc;
        if (i_rx_valid || err_now || (wd_inc >= wd_limit)) begin
          state_d    = ST_IDLE;
          leave_recv = 1'b1;
        end
        if (i_cfg_we) begin
          pend_vld_d      = 1'b1;
          pend_prsc_d     = i_cfg_prescale;
          pend_par_en_d   = i_cfg_par_en;
          pend_par_type_d = i_cfg_par_type;
        end
        // a write landing on the exit cycle is newer than anything pending
        if (leave_recv) begin
          pend_vld_d = 1'b0;
          if (i_cfg_we) begin
            prsc_d     = i_cfg_prescale;
            par_en_d   = i_cfg_par_en;
            par_type_d = i_cfg_par_type;
          end else if (pend_vld_q) begin
            prsc_d     = pend_prsc_q;
            par_en_d   = pend_par_en_q;
            par_type_d = pend_par_type_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    // frame_err_q marks a frame already charged with an error, so a held indication counts once
    err_evt     = err_now && !frame_err_q;
    frame_err_d = err_now ? 1'b1 :
                  ((state_q == ST_IDLE && !i_serial_data) ? 1'b0 : frame_err_q);
    push_req    = i_rx_valid && !err_now && !frame_err_q;

    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = i_rd_en && !empty;
    do_push = push_req && (!full || do_pop);
    ovr_evt = push_req && full && !do_pop;

    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);

    par_flag_d = (par_flag_q & ~i_clr_err) | (err_evt & i_rx_par_err);
    stp_flag_d = (stp_flag_q & ~i_clr_err) | (err_evt & i_rx_stp_err);
    ovr_flag_d = (ovr_flag_q & ~i_clr_err) | ovr_evt;
    err_cnt_d  = err_cnt_q;
    if (i_clr_err)                                  err_cnt_d = (err_evt || ovr_evt) ? 8'd1 : 8'd0;
    else if ((err_evt || ovr_evt) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    tmo_cnt_d = tmo_cnt_q;
    if (empty || do_push || do_pop)      tmo_cnt_d = '0;
    else if (tmo_cnt_q != TW'(TMO_CYC))  tmo_cnt_d = tmo_cnt_q + TW'(1);
    timeout = (tmo_cnt_q == TW'(TMO_CYC));

    irq_d = ((count_q >= i_thresh) && (i_thresh != '0)) ||
            par_flag_q || stp_flag_q || ovr_flag_q || timeout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      wd_q            <= '0;
      prsc_q          <= PRSC_RST;
      par_en_q        <= 1'b0;
      par_type_q      <= 1'b0;
      pend_vld_q      <= 1'b0;
      pend_prsc_q     <= '0;
      pend_par_en_q   <= 1'b0;
      pend_par_type_q <= 1'b0;
      frame_err_q     <= 1'b0;
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      par_flag_q      <= 1'b0;
      stp_flag_q      <= 1'b0;
      ovr_flag_q      <= 1'b0;
      err_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      prsc_q          <= prsc_d;
      par_en_q        <= par_en_d;
      par_type_q      <= par_type_d;
      pend_vld_q      <= pend_vld_d;
      pend_prsc_q     <= pend_prsc_d;
      pend_par_en_q   <= pend_par_en_d;
      pend_par_type_q <= pend_par_type_d;
      frame_err_q     <= frame_err_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      par_flag_q      <= par_flag_d;
      stp_flag_q      <= stp_flag_d;
      ovr_flag_q      <= ovr_flag_d;
      err_cnt_q       <= err_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      irq_q           <= irq_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= i_rx_data;
  end

  assign o_prescale      = prsc_q;
  assign o_parity_enable = par_en_q;
  assign o_parity_type   = par_type_q;
  assign o_rd_data       = empty ? '0 : mem_q[rptr_q];
  assign o_empty         = empty;
  assign o_full          = full;
  assign o_count         = count_q;
  assign o_par_flag      = par_flag_q;
  assign o_stp_flag      = stp_flag_q;
  assign o_ovr_flag      = ovr_flag_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a queue-based reference model
module tb_uart_rx_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 6;
  localparam int TMO   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_serial_data = 1'b1, i_rx_valid = 1'b0, i_rx_par_err = 1'b0, i_rx_stp_err = 1'b0;
  logic [WIDTH-1:0] i_rx_data = '0;
  logic i_cfg_we = 1'b0, i_cfg_par_en = 1'b0, i_cfg_par_type = 1'b0;
  logic [PW-1:0] i_cfg_prescale = '0;
  logic [PW-1:0] o_prescale;
  logic o_parity_enable, o_parity_type;
  logic i_rd_en = 1'b0;
  logic [WIDTH-1:0] o_rd_data;
  logic o_empty, o_full;
  logic [3:0] o_count;
  logic [3:0] i_thresh = '0;
  logic i_clr_err = 1'b0;
  logic o_par_flag, o_stp_flag, o_ovr_flag, o_irq;
  logic [7:0] o_err_cnt;

  uart_rx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRSC_WIDTH(PW), .TMO_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_serial_data(i_serial_data),
    .i_rx_valid(i_rx_valid), .i_rx_par_err(i_rx_par_err), .i_rx_stp_err(i_rx_stp_err),
    .i_rx_data(i_rx_data), .i_cfg_we(i_cfg_we), .i_cfg_prescale(i_cfg_prescale),
    .i_cfg_par_en(i_cfg_par_en), .i_cfg_par_type(i_cfg_par_type),
    .o_prescale(o_prescale), .o_parity_enable(o_parity_enable), .o_parity_type(o_parity_type),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_empty(o_empty), .o_full(o_full),
    .o_count(o_count), .i_thresh(i_thresh), .i_clr_err(i_clr_err),
    .o_par_flag(o_par_flag), .o_stp_flag(o_stp_flag), .o_ovr_flag(o_ovr_flag),
    .o_err_cnt(o_err_cnt), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  int m_cnt = 0;
  int m_err = 0;
  bit m_par = 0, m_stp = 0, m_ovr = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every accepted pop must present the oldest expected byte
  initial forever begin
    @(negedge clk);
    if (!rst && i_rd_en && !o_empty) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got %0h expected none", o_rd_data);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("rd_data", {24'd0, o_rd_data}, {24'd0, e});
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_frame(logic [7:0] d, bit perr, bit serr, bit pop);
    bit p;
    p = pop && (m_cnt > 0);
    if (perr || serr) begin
      bump_err(); m_par |= perr; m_stp |= serr;
    end else if (m_cnt < DEPTH || p) begin
      sb_q.push_back(d); m_cnt++;
    end else begin
      m_ovr = 1; bump_err();
    end
    if (p) m_cnt--;
  endtask

  // ends just after the edge that samples i_rx_valid (hold>1 keeps errors up longer)
  task automatic frame(logic [7:0] d, bit perr, bit serr, bit pop, int hold);
    i_serial_data = 1'b0; tick();
    i_serial_data = 1'b1; tick($urandom_range(1, 4));
    i_rx_data = d; i_rx_valid = 1'b1; i_rx_par_err = perr; i_rx_stp_err = serr; i_rd_en = pop;
    model_frame(d, perr, serr, pop);
    tick();
    i_rx_valid = 1'b0; i_rd_en = 1'b0;
    if (hold > 1) tick(hold - 1);
    i_rx_par_err = 1'b0; i_rx_stp_err = 1'b0;
  endtask

  task automatic pop1();
    i_rd_en = 1'b1;
    if (m_cnt > 0) m_cnt--;
    tick();
    i_rd_en = 1'b0;
  endtask

  task automatic clr();
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    m_err = 0; m_par = 0; m_stp = 0; m_ovr = 0;
  endtask

  task automatic cfg(logic [PW-1:0] p, bit en, bit ty);
    i_cfg_we = 1'b1; i_cfg_prescale = p; i_cfg_par_en = en; i_cfg_par_type = ty;
  endtask

  task automatic status(string tag);
    chk({tag, ".count"}, {28'd0, o_count}, m_cnt);
    chk({tag, ".empty"}, {31'd0, o_empty}, (m_cnt == 0));
    chk({tag, ".full"},  {31'd0, o_full},  (m_cnt == DEPTH));
    chk({tag, ".err"},   {24'd0, o_err_cnt}, m_err);
    chk({tag, ".par"},   {31'd0, o_par_flag}, m_par);
    chk({tag, ".stp"},   {31'd0, o_stp_flag}, m_stp);
    chk({tag, ".ovr"},   {31'd0, o_ovr_flag}, m_ovr);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, ".empty"}, {31'd0, o_empty}, 1);
    chk({tag, ".full"},  {31'd0, o_full}, 0);
    chk({tag, ".count"}, {28'd0, o_count}, 0);
    chk({tag, ".rd"},    {24'd0, o_rd_data}, 0);
    chk({tag, ".err"},   {24'd0, o_err_cnt}, 0);
    chk({tag, ".flags"}, {29'd0, o_par_flag, o_stp_flag, o_ovr_flag}, 0);
    chk({tag, ".irq"},   {31'd0, o_irq}, 0);
    chk({tag, ".presc"}, {26'd0, o_prescale}, 8);
    chk({tag, ".par_cfg"}, {30'd0, o_parity_enable, o_parity_type}, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 reset_checks("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // two pushes, fall-through head, then pop
    frame(8'hA5, 0, 0, 0, 1);
    frame(8'h3C, 0, 0, 0, 1);
    status("two");
    chk("head_a5", {24'd0, o_rd_data}, 32'hA5);
    pop1();
    chk("head_3c", {24'd0, o_rd_data}, 32'h3C);
    pop1();
    status("drained");

    // overrun on the 9th push, then push+pop on a full FIFO
    for (int i = 0; i < 9; i++) frame(8'($urandom), 0, 0, 0, 1);
    status("ovr");
    for (int i = 0; i < 8; i++) pop1();
    clr();
    for (int i = 0; i < 8; i++) frame(8'($urandom), 0, 0, 0, 1);
    frame(8'($urandom), 0, 0, 1, 1);
    status("full_pushpop");
    for (int i = 0; i < 8; i++) pop1();

    // parity error held three cycles counts once and pushes nothing
    frame(8'h77, 1, 0, 0, 3);
    tick();
    status("par3");
    clr();
    status("clr");
    frame(8'h11, 1, 0, 0, 1);
    i_serial_data = 1'b0; tick(); i_serial_data = 1'b1; tick(2);
    i_rx_valid = 1'b1; i_rx_stp_err = 1'b1; i_clr_err = 1'b1;
    tick();
    i_rx_valid = 1'b0; i_rx_stp_err = 1'b0; i_clr_err = 1'b0;
    m_err = 1; m_par = 0; m_stp = 1; m_ovr = 0;
    status("clr_vs_err");
    clr();

    // error counter saturation
    for (int i = 0; i < 260; i++) frame(8'($urandom), 0, 1, 0, 1);
    status("sat");
    clr();

    // configuration: direct write in IDLE, staged writes during RECV
    cfg(6'd5, 1, 1); tick(); i_cfg_we = 1'b0;
    chk("cfg_idle", {24'd0, o_parity_enable, o_parity_type, o_prescale}, {24'd0, 2'b11, 6'd5});
    cfg(6'd8, 0, 0); tick(); i_cfg_we = 1'b0;
    i_serial_data = 1'b0; tick(); i_serial_data = 1'b1; tick();
    cfg(6'd20, 1, 0); tick(); i_cfg_we = 1'b0; tick();
    cfg(6'd16, 0, 1); tick(); i_cfg_we = 1'b0;
    chk("cfg_held", {26'd0, o_prescale}, 8);
    i_rx_data = 8'h5A; i_rx_valid = 1'b1; model_frame(8'h5A, 0, 0, 0);
    tick(); i_rx_valid = 1'b0;
    chk("cfg_applied", {24'd0, o_parity_enable, o_parity_type, o_prescale}, {24'd0, 2'b01, 6'd16});
    pop1();

    // watchdog exit after 12*16 clocks applies the pending write
    i_serial_data = 1'b0; tick(); i_serial_data = 1'b1;
    cfg(6'd4, 0, 0); tick(); i_cfg_we = 1'b0;
    tick(190);
    chk("wd_before", {26'd0, o_prescale}, 16);
    tick();
    chk("wd_after", {26'd0, o_prescale}, 4);
    cfg(6'd8, 0, 0); tick(); i_cfg_we = 1'b0;

    // threshold interrupt
    i_thresh = 4'd4; tick(2);
    for (int i = 0; i < 4; i++) frame(8'($urandom), 0, 0, 0, 1);
    chk("irq_lag", {31'd0, o_irq}, 0);
    tick();
    chk("irq_thresh", {31'd0, o_irq}, 1);
    i_thresh = 4'd5; tick(2);
    chk("irq_below", {31'd0, o_irq}, 0);
    i_thresh = 4'd0;
    for (int i = 0; i < 4; i++) pop1();

    // idle timeout interrupt
    frame(8'hC3, 0, 0, 0, 1);
    tick(TMO);
    chk("tmo_before", {31'd0, o_irq}, 0);
    tick();
    chk("tmo_irq", {31'd0, o_irq}, 1);
    pop1(); tick();
    chk("tmo_clear", {31'd0, o_irq}, 0);

    // reset mid-frame discards frame, contents and pending config
    frame(8'h01, 0, 0, 0, 1);
    frame(8'h02, 0, 0, 0, 1);
    i_serial_data = 1'b0; tick(); i_serial_data = 1'b1;
    cfg(6'd30, 1, 1); tick(); i_cfg_we = 1'b0;
    i_rx_valid = 1'b1; i_rx_par_err = 1'b1;
    #1 rst = 1'b1;
    #2 reset_checks("midrst");
    i_rx_valid = 1'b0; i_rx_par_err = 1'b0;
    sb_q.delete(); m_cnt = 0; m_err = 0; m_par = 0; m_stp = 0; m_ovr = 0;
    @(posedge clk); #1 rst = 1'b0;
    tick();
    frame(8'h9E, 0, 0, 0, 1);
    chk("midrst_cfg", {26'd0, o_prescale}, 8);
    status("midrst_after");
    pop1();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 15);
      frame(8'($urandom), (r == 0), (r == 1), bit'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 3) == 0) pop1();
    end
    status("random");
    while (m_cnt > 0) pop1();
    pop1();
    status("final");
    tick(2);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
